// File: rtl/cram_async_ctrl_pkg.sv
// cram_async_ctrl_pkg
//   Shared types for the asynchronous-mode cellular RAM controller:
//   FSM state encoding, latched request record, registered bus image,
//   and small elaboration-time helpers for sizing the cycle counter.
package cram_async_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_READ    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RECOVER = 3'd4
  } cram_state_e;

  // Address is stored at the widest supported size (two chips, 23 bits).
  typedef struct packed {
    logic        write;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } cram_req_t;

  // Everything the controller drives onto the bus, registered as one unit.
  typedef struct packed {
    logic        ce0_n;
    logic        ce1_n;
    logic        adv_n;
    logic        oe_n;
    logic        we_n;
    logic        ub_n;
    logic        lb_n;
    logic [5:0]  a;
    logic [15:0] data_in;
  } cram_bus_t;

  localparam cram_bus_t BUS_RESET = '{
    ce0_n: 1'b1, ce1_n: 1'b1, adv_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
    ub_n: 1'b1, lb_n: 1'b1, a: 6'd0, data_in: 16'd0
  };

  function automatic int max4(int p, int q, int r, int s);
    int m;
    m = p;
    if (q > m) m = q;
    if (r > m) m = r;
    if (s > m) m = s;
    return m;
  endfunction

  // Bits needed to hold values 0 .. m-1, never less than one.
  function automatic int cnt_width(int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/cram_async_ctrl_if.sv
// cram_if
//   Pin-level bundle between the controller and cram_connect / the device.
//   master : controller side (drives strobes, address and data_in,
//            samples data_out).
//   slave  : device / tristate side.
//   data_in is what goes onto dq while oe_n=1; data_out is what dq carries
//   back; in_en tells the tristate owner to turn dq around for a read.
interface cram_if;
  logic        clk;
  logic [21:16] a;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        in_en;
  logic        adv_n;
  logic        ce0_n;
  logic        ce1_n;
  logic        cre;
  logic        oe_n;
  logic        we_n;
  logic        ub_n;
  logic        lb_n;
  logic        _wait;

  modport master (
    output clk, a, data_in, in_en, adv_n, ce0_n, ce1_n, cre, oe_n, we_n,
           ub_n, lb_n,
    input  data_out, _wait
  );

  modport slave (
    input  clk, a, data_in, in_en, adv_n, ce0_n, ce1_n, cre, oe_n, we_n,
           ub_n, lb_n,
    output data_out, _wait
  );
endinterface

// File: rtl/cram_async_ctrl.sv
// cram_async_ctrl
//   Turns a single-word request stream into timed asynchronous-mode
//   ADV/CE/OE/WE/UB/LB sequences on a cram_if, returning read data with a
//   one-cycle rsp_valid pulse.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   req_valid/ready   : request handshake
//   req_write/addr/wdata/be : request payload, sampled only on accept
//   rsp_valid/rdata   : read response (rdata held until next read)
//   busy              : state != IDLE
//   dbg_state         : current FSM state
//   cram              : bus to cram_connect / device (master side)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is a function of registered state
// only (IDLE, or the last RECOVER cycle), never of req_valid.
module cram_async_ctrl
  import cram_async_ctrl_pkg::*;
#(
  parameter int NUM_CHIPS  = 1,
  parameter int ADDR_WIDTH = 22 + ((NUM_CHIPS == 2) ? 1 : 0),
  parameter int T_ADV      = 2,
  parameter int T_RD       = 6,
  parameter int T_WR       = 6,
  parameter int T_REC      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]           req_wdata,
  input  logic [1:0]            req_be,
  output logic                  rsp_valid,
  output logic [15:0]           rsp_rdata,
  output logic                  busy,
  output cram_state_e           dbg_state,
  cram_if.master                cram
);

  localparam int CW = cnt_width(max4(T_ADV, T_RD, T_WR, T_REC));
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t LD_ADV = cnt_t'(T_ADV - 1);
  localparam cnt_t LD_RD  = cnt_t'(T_RD - 1);
  localparam cnt_t LD_WR  = cnt_t'(T_WR - 1);
  localparam cnt_t LD_REC = cnt_t'(T_REC - 1);

  cram_state_e state, state_n;
  cnt_t        cnt, cnt_n;
  cram_req_t   req_q, req_n, req_in;
  cram_bus_t   bus_q, bus_n;
  logic        take, take_access, rd_done;

  // Chip 1 is addressed by bit 22, only when two chips are fitted.
  function automatic logic hi_chip(cram_req_t r);
    return (NUM_CHIPS == 2) && r.addr[22];
  endfunction

  assign req_in = '{write: req_write, addr: 23'(req_addr),
                    wdata: req_wdata, be: req_be};

  assign req_ready   = (state == ST_IDLE) ||
                       ((state == ST_RECOVER) && (cnt == '0));
  assign take        = req_valid && req_ready;
  // A write with no byte lanes enabled is consumed without touching the bus.
  assign take_access = take && !(req_write && (req_be == 2'b00));
  assign rd_done     = (state == ST_READ) && (cnt == '0);

  // Next state, counter and latched request.
  always_comb begin
    state_n = state;
    cnt_n   = (cnt == '0) ? cnt : cnt - cnt_t'(1);
    req_n   = req_q;
    case (state)
      ST_IDLE: begin
        if (take_access) begin
          state_n = ST_ADDR;
          cnt_n   = LD_ADV;
          req_n   = req_in;
        end
      end
      ST_ADDR: begin
        if (cnt == '0) begin
          state_n = req_q.write ? ST_WRITE : ST_READ;
          cnt_n   = req_q.write ? LD_WR : LD_RD;
        end
      end
      ST_READ, ST_WRITE: begin
        if (cnt == '0) begin
          state_n = ST_RECOVER;
          cnt_n   = LD_REC;
        end
      end
      ST_RECOVER: begin
        if (cnt == '0) begin
          // Accepting here keeps back-to-back accesses free of an IDLE bubble.
          if (take_access) begin
            state_n = ST_ADDR;
            cnt_n   = LD_ADV;
            req_n   = req_in;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Bus image for the state being entered; registered so pins never glitch.
  always_comb begin
    bus_n       = bus_q;
    bus_n.ce0_n = 1'b1;
    bus_n.ce1_n = 1'b1;
    bus_n.adv_n = 1'b1;
    bus_n.oe_n  = 1'b1;
    bus_n.we_n  = 1'b1;
    bus_n.ub_n  = 1'b1;
    bus_n.lb_n  = 1'b1;
    case (state_n)
      ST_ADDR: begin
        bus_n.ce0_n   = hi_chip(req_n);
        bus_n.ce1_n   = ~hi_chip(req_n);
        bus_n.adv_n   = 1'b0;
        bus_n.a       = req_n.addr[21:16];
        bus_n.data_in = req_n.addr[15:0];
      end
      ST_READ: begin
        bus_n.ce0_n = hi_chip(req_n);
        bus_n.ce1_n = ~hi_chip(req_n);
        bus_n.oe_n  = 1'b0;
        bus_n.ub_n  = 1'b0;
        bus_n.lb_n  = 1'b0;
      end
      ST_WRITE: begin
        bus_n.ce0_n   = hi_chip(req_n);
        bus_n.ce1_n   = ~hi_chip(req_n);
        bus_n.we_n    = 1'b0;
        bus_n.ub_n    = ~req_n.be[1];
        bus_n.lb_n    = ~req_n.be[0];
        bus_n.data_in = req_n.wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_q     <= '0;
      bus_q     <= BUS_RESET;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      req_q     <= req_n;
      bus_q     <= bus_n;
      rsp_valid <= rd_done;
      if (rd_done) rsp_rdata <= cram.data_out;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  assign cram.clk     = 1'b0;
  assign cram.cre     = 1'b0;
  assign cram.ce0_n   = bus_q.ce0_n;
  assign cram.ce1_n   = bus_q.ce1_n;
  assign cram.adv_n   = bus_q.adv_n;
  assign cram.oe_n    = bus_q.oe_n;
  assign cram.we_n    = bus_q.we_n;
  assign cram.ub_n    = bus_q.ub_n;
  assign cram.lb_n    = bus_q.lb_n;
  assign cram.a       = bus_q.a;
  assign cram.data_in = bus_q.data_in;
  assign cram.in_en   = ~bus_q.oe_n;

endmodule

// File: tb/tb_cram_async_ctrl.sv
// tb_cram_async_ctrl
//   Two controllers: u_dut0 with default parameters (one chip, 2/6/6/2) and
//   u_dut1 with two chips and 1/3/2/1 timing. Each has a small behavioural
//   PSRAM on its cram_if. Read expectations come from a reference memory
//   updated as requests are accepted, queued with their due cycle.
module tb_cram_async_ctrl;
  import cram_async_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [22:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic [1:0]  req_be    [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_rdata [2];
  logic        busy      [2];
  cram_state_e dbg_state [2];
  logic [31:0] bv        [2];
  logic [15:0] dout      [2] = '{16'hDEAD, 16'hDEAD};

  cram_if cif0 ();
  cram_if cif1 ();

  cram_async_ctrl u_dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0][21:0]), .req_wdata(req_wdata[0]),
    .req_be(req_be[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .busy(busy[0]), .dbg_state(dbg_state[0]), .cram(cif0.master)
  );

  cram_async_ctrl #(.NUM_CHIPS(2), .T_ADV(1), .T_RD(3), .T_WR(2), .T_REC(1)) u_dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_be(req_be[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .busy(busy[1]), .dbg_state(dbg_state[1]), .cram(cif1.master)
  );

  // Bus snapshot: clk31 cre30 in_en29 ce0 28 ce1 27 adv26 oe25 we24 ub23 lb22 a21:16 din15:0
  assign bv[0] = {cif0.clk, cif0.cre, cif0.in_en, cif0.ce0_n, cif0.ce1_n, cif0.adv_n,
                  cif0.oe_n, cif0.we_n, cif0.ub_n, cif0.lb_n, cif0.a, cif0.data_in};
  assign bv[1] = {cif1.clk, cif1.cre, cif1.in_en, cif1.ce0_n, cif1.ce1_n, cif1.adv_n,
                  cif1.oe_n, cif1.we_n, cif1.ub_n, cif1.lb_n, cif1.a, cif1.data_in};
  assign cif0.data_out = dout[0];
  assign cif1.data_out = dout[1];
  assign cif0._wait    = 1'b0;
  assign cif1._wait    = 1'b0;

  function automatic int tadv(int d); return (d == 0) ? 2 : 1; endfunction
  function automatic int trd (int d); return (d == 0) ? 6 : 3; endfunction
  function automatic int twr (int d); return (d == 0) ? 6 : 2; endfunction
  function automatic int trec(int d); return (d == 0) ? 2 : 1; endfunction

  function automatic logic [31:0] mk(logic ce0, logic ce1, logic adv, logic oe, logic we,
                                     logic ub, logic lb, logic [5:0] a, logic [15:0] din);
    return {1'b0, 1'b0, ~oe, ce0, ce1, adv, oe, we, ub, lb, a, din};
  endfunction

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural PSRAM ----------------
  logic [15:0] pmem [int];
  logic [22:0] lat  [2];
  int          n_act[2] = '{0, 0};

  always @(negedge clk) begin : psram
    logic [31:0] b;
    int          key;
    logic [15:0] w;
    for (int d = 0; d < 2; d++) begin
      b = bv[d];
      if (!b[26] && (!b[28] || !b[27])) lat[d] = {~b[27], b[21:0]};
      key = d * (1 << 24) + int'(lat[d]);
      if (!b[24] && (!b[28] || !b[27])) begin
        w = pmem.exists(key) ? pmem[key] : 16'h0000;
        if (!b[23]) w[15:8] = b[15:8];
        if (!b[22]) w[7:0]  = b[7:0];
        pmem[key] = w;
      end
      if (!b[25]) dout[d] = pmem.exists(key) ? pmem[key] : 16'h0000;
      else        dout[d] = 16'hDEAD;
      if (!(b[28] & b[27] & b[26] & b[25] & b[24])) n_act[d]++;
    end
  end

  // ---------------- scoreboard ----------------
  logic [15:0] ref_mem [int];
  logic [15:0] exp_q   [2][$];
  int          exp_t_q [2][$];

  always @(negedge clk) begin : rsp_mon
    logic [15:0] e;
    int          t;
    for (int d = 0; d < 2; d++) begin
      if (rsp_valid[d] === 1'b1) begin
        if (exp_q[d].size() == 0) begin
          check("rsp_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q[d].pop_front();
          t = exp_t_q[d].pop_front();
          check("rsp_data", rsp_rdata[d], e);
          check("rsp_time", cyc, t);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a falling edge. Leaves req_valid high on return.
  task automatic send(input int d, input logic w, input logic [22:0] ad,
                      input logic [15:0] wd, input logic [1:0] be, output int t_acc);
    int k;
    int key;
    logic [15:0] m;
    k = 0;
    req_valid[d] = 1'b1;
    req_write[d] = w;
    req_addr[d]  = ad;
    req_wdata[d] = wd;
    req_be[d]    = be;
    while (!req_ready[d] && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("accept_timeout", k < 100, 1'b1);
    @(negedge clk);
    t_acc = cyc;
    key = d * (1 << 24) + int'(ad);
    m = ref_mem.exists(key) ? ref_mem[key] : 16'h0000;
    if (w) begin
      if (be[1]) m[15:8] = wd[15:8];
      if (be[0]) m[7:0]  = wd[7:0];
      ref_mem[key] = m;
    end else begin
      exp_q[d].push_back(m);
      exp_t_q[d].push_back(t_acc + tadv(d) + trd(d));
    end
  endtask

  // One access with a per-cycle check of the bus, req_ready and busy.
  task automatic access(input int d, input logic w, input logic [22:0] ad,
                        input logic [15:0] wd, input logic [1:0] be);
    int t0, ta, tx, tot;
    logic chip;
    logic [31:0] e, m;
    ta   = tadv(d);
    tx   = w ? twr(d) : trd(d);
    tot  = ta + tx + trec(d);
    chip = (d == 1) && ad[22];
    send(d, w, ad, wd, be, t0);
    req_valid[d] = 1'b0;
    for (int i = 0; i < tot; i++) begin
      m = 32'hFFFF_FFFF;
      if (i < ta) begin
        e = mk(chip, !chip, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, ad[21:16], ad[15:0]);
        m[23:22] = 2'b00;
      end else if (i < ta + tx) begin
        if (w) e = mk(chip, !chip, 1'b1, 1'b1, 1'b0, !be[1], !be[0], ad[21:16], wd);
        else begin
          e = mk(chip, !chip, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ad[21:16], 16'h0);
          m[15:0] = 16'h0;
        end
      end else begin
        e = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'h0, 16'h0);
        m[21:0] = 22'h0;
      end
      check(w ? "wr_bus" : "rd_bus", bv[d] & m, e & m);
      check("ready", req_ready[d], i == tot - 1);
      check("busy", busy[d], 1'b1);
      @(negedge clk);
    end
    check("idle_after", {busy[d], req_ready[d]}, 2'b01);
  endtask

  // ---------------- main sequence ----------------
  logic        b_w  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [22:0] b_a  [4] = '{23'h000100, 23'h000100, 23'h400100, 23'h400100};
  logic [15:0] b_d  [4] = '{16'h1111, 16'h0000, 16'h2222, 16'h0000};
  logic [1:0]  b_be [4] = '{2'b11, 2'b00, 2'b01, 2'b00};
  int          ts   [4];

  initial begin
    int t;
    int act0;
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0; req_be[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_bus", bv[d], mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'h0, 16'h0));
      check("rst_out", {rsp_valid[d], rsp_rdata[d], busy[d]}, 18'h0);
      check("rst_state", dbg_state[d], ST_IDLE);
    end
    reset[0] = 1'b0; reset[1] = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {req_ready[0], req_ready[1]}, 2'b11);

    // Defaults: single write, read back, byte write, read back.
    access(0, 1'b1, 23'h012345, 16'hBEEF, 2'b11);
    access(0, 1'b0, 23'h012345, 16'h0000, 2'b00);
    access(0, 1'b1, 23'h012345, 16'h00AA, 2'b10);
    access(0, 1'b0, 23'h012345, 16'h0000, 2'b00);

    // Reset during WRITE cycle 3: bus must drop at once.
    send(0, 1'b1, 23'h003000, 16'h5555, 2'b11, t);
    req_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset[0] = 1'b1;
    #1 check("rst_abort_wr", {bv[0][28], bv[0][27], bv[0][24], bv[0][25], bv[0][26],
                              busy[0], rsp_valid[0]}, 7'b1111100);
    @(negedge clk);
    reset[0] = 1'b0;
    @(negedge clk);
    check("ready_after_abort_wr", {req_ready[0], busy[0]}, 2'b10);

    // Reset during READ: the pending response is withdrawn and must not appear.
    send(0, 1'b0, 23'h012345, 16'h0000, 2'b00, t);
    req_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset[0] = 1'b1;
    #1 check("rst_abort_rd", {bv[0][28], bv[0][25], bv[0][29], busy[0], rsp_valid[0]},
             5'b11000);
    exp_q[0].delete();
    exp_t_q[0].delete();
    @(negedge clk);
    reset[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("ready_after_abort_rd", {req_ready[0], busy[0]}, 2'b10);

    // Two chips: bit 22 routes to ce1_n only; chip 0 at the same offset is untouched.
    access(1, 1'b1, 23'h401234, 16'h5A5A, 2'b11);
    access(1, 1'b0, 23'h401234, 16'h0000, 2'b00);
    access(1, 1'b0, 23'h001234, 16'h0000, 2'b00);

    // be=0 write: accepted, no bus activity, stays ready.
    act0 = n_act[1];
    send(1, 1'b1, 23'h000777, 16'h7777, 2'b00, t);
    req_valid[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("be0_idle", {req_ready[1], busy[1]}, 2'b10);
      @(negedge clk);
    end
    check("be0_no_activity", n_act[1] - act0, 0);

    // Back-to-back with req_valid held high.
    for (int i = 0; i < 4; i++) send(1, b_w[i], b_a[i], b_d[i], b_be[i], ts[i]);
    req_valid[1] = 1'b0;
    for (int i = 1; i < 4; i++)
      check("b2b_gap", ts[i] - ts[i-1],
            tadv(1) + (b_w[i-1] ? twr(1) : trd(1)) + trec(1));

    repeat (15) @(negedge clk);
    check("q0_empty", exp_q[0].size(), 0);
    check("q1_empty", exp_q[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
